seq_div8x4: RTL and testbench



---
 rtl/seq_div8x4_pkg.sv | 16 +
 rtl/seq_div8x4_if.sv | 24 ++
 rtl/seq_div8x4_div_step.sv | 23 ++
 rtl/seq_div8x4.sv | 110 +++++++++++
 tb/tb_seq_div8x4.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/seq_div8x4_pkg.sv
// rtl/seq_div8x4_pkg.sv - shared types and constants for the 8/4 sequential divider
package seq_div_pkg;

  localparam int DW    = 4;
  localparam int ITERS = DW;
  localparam int CW    = $clog2(ITERS);

  localparam logic [DW-1:0] Q_ERR = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div8x4_if.sv
// rtl/seq_div8x4_if.sv - START/READY request and result bundle of the divider
interface seq_div8x4_if;
  import seq_div_pkg::*;

  logic            START;
  logic [2*DW-1:0] N;
  logic [DW-1:0]   D;
  logic [DW-1:0]   Q;
  logic [DW-1:0]   R;
  logic            READY;
  logic            OVF;
  logic            DIVZ;

  modport master (
    output START, N, D,
    input  Q, R, READY, OVF, DIVZ
  );

  modport slave (
    input  START, N, D,
    output Q, R, READY, OVF, DIVZ
  );

endinterface

// File: rtl/seq_div8x4_div_step.sv
// rtl/seq_div8x4_div_step.sv - one restoring-division iteration, purely combinational
module div_step
  import seq_div_pkg::*;
(
  input  logic [DW:0]   pr,
  input  logic          bit_in,
  input  logic [DW-1:0] dr,
  output logic [DW:0]   pr_next,
  output logic          q_bit
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] diff;

  // One spare bit above the partial remainder makes the top bit of diff the borrow.
  always_comb begin
    shifted = {pr, bit_in};
    diff    = shifted - {2'b00, dr};
    q_bit   = ~diff[DW+1];
    pr_next = q_bit ? diff[DW:0] : shifted[DW:0];
  end

endmodule

// File: rtl/seq_div8x4.sv
// rtl/seq_div8x4.sv - sequential restoring divider, 8-bit dividend by 4-bit divisor
module seq_div8x4
  import seq_div_pkg::*;
(
  input  logic        blif_clk_net,
  input  logic        blif_reset_net,
  seq_div8x4_if.slave bus
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW:0]   pr;
  logic [DW-1:0] sq;
  logic [DW-1:0] dr;
  logic          err_divz;
  logic          err_ovf;

  logic [DW-1:0] q_r;
  logic [DW-1:0] r_r;
  logic          ovf_r;
  logic          divz_r;
  logic          ready_r;

  logic [DW:0]   pr_next;
  logic          q_bit;

  div_step u_step (
    .pr      (pr),
    .bit_in  (sq[DW-1]),
    .dr      (dr),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state    <= IDLE;
      cnt      <= '0;
      pr       <= '0;
      sq       <= '0;
      dr       <= '0;
      err_divz <= 1'b0;
      err_ovf  <= 1'b0;
      q_r      <= '0;
      r_r      <= '0;
      ovf_r    <= 1'b0;
      divz_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.START) begin
            cnt     <= '0;
            ready_r <= 1'b0;
            state   <= RUN;
            if (bus.D == '0) begin
              err_divz <= 1'b1;
              err_ovf  <= 1'b0;
            end else if (bus.N[2*DW-1:DW] >= bus.D) begin
              err_divz <= 1'b0;
              err_ovf  <= 1'b1;
            end else begin
              err_divz <= 1'b0;
              err_ovf  <= 1'b0;
              pr       <= {1'b0, bus.N[2*DW-1:DW]};
              sq       <= bus.N[DW-1:0];
              dr       <= bus.D;
            end
          end
        end
        RUN: begin
          // Error requests spend exactly one cycle here before reporting.
          if (err_divz || err_ovf) begin
            q_r      <= Q_ERR;
            r_r      <= '0;
            ovf_r    <= err_ovf;
            divz_r   <= err_divz;
            err_divz <= 1'b0;
            err_ovf  <= 1'b0;
            ready_r  <= 1'b1;
            state    <= DONE;
          end else begin
            pr  <= pr_next;
            sq  <= {sq[DW-2:0], q_bit};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(ITERS-1)) begin
              q_r     <= {sq[DW-2:0], q_bit};
              r_r     <= pr_next[DW-1:0];
              ovf_r   <= 1'b0;
              divz_r  <= 1'b0;
              ready_r <= 1'b1;
              state   <= DONE;
            end
          end
        end
        default: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.Q     = q_r;
  assign bus.R     = r_r;
  assign bus.OVF   = ovf_r;
  assign bus.DIVZ  = divz_r;
  assign bus.READY = ready_r;

endmodule

// File: tb/tb_seq_div8x4.sv
// tb/tb_seq_div8x4.sv - directed and exhaustive checks of seq_div8x4
module tb_seq_div8x4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;

  seq_div8x4_if bus ();

  seq_div8x4 dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] n, input logic [3:0] d);
    @(negedge clk);
    bus.N     = n;
    bus.D     = d;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
  endtask

  task automatic wait_ready(output int l);
    l = 0;
    while (bus.READY !== 1'b1 && l < 12) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] n, input logic [3:0] d,
                        input int exp_lat, input logic [3:0] eq, input logic [3:0] er,
                        input logic eovf, input logic edivz);
    logic [3:0] prev_q;
    int l;
    prev_q = bus.Q;
    launch(n, d);
    chk({tag, "_ready_low"}, bus.READY, 1'b0);
    chk({tag, "_q_hold"}, bus.Q, prev_q);
    wait_ready(l);
    chk({tag, "_latency"}, l, exp_lat);
    chk({tag, "_q"}, bus.Q, eq);
    chk({tag, "_r"}, bus.R, er);
    chk({tag, "_ovf"}, bus.OVF, eovf);
    chk({tag, "_divz"}, bus.DIVZ, edivz);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.N     = '0;
    bus.D     = '0;

    #1 rst = 1'b1;
    #2;
    chk("rst_ready", bus.READY, 1'b1);
    chk("rst_q", bus.Q, 4'h0);
    chk("rst_r", bus.R, 4'h0);
    chk("rst_ovf", bus.OVF, 1'b0);
    chk("rst_divz", bus.DIVZ, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("n225_d15", 8'd225, 4'd15, 4, 4'd15, 4'd0, 1'b0, 1'b0);
    run_op("n79_d5", 8'h4F, 4'd5, 4, 4'd15, 4'd4, 1'b0, 1'b0);

    // Back-to-back with START held: 100/7 then 45/9 at 5-cycle spacing.
    launch(8'd100, 4'd7);
    bus.START = 1'b1;
    bus.N     = 8'd45;
    bus.D     = 4'd9;
    chk("b2b_first_accept", bus.READY, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_busy_k3", bus.READY, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b_ready_k4", bus.READY, 1'b1);
    chk("b2b_q1", bus.Q, 4'd14);
    chk("b2b_r1", bus.R, 4'd2);
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    chk("b2b_second_accept", bus.READY, 1'b0);
    chk("b2b_q1_hold", bus.Q, 4'd14);
    wait_ready(lat);
    chk("b2b_lat2", lat, 4);
    chk("b2b_q2", bus.Q, 4'd5);
    chk("b2b_r2", bus.R, 4'd0);

    run_op("divz", 8'h37, 4'd0, 1, 4'hF, 4'd0, 1'b0, 1'b1);
    run_op("ovf", 8'h50, 4'd5, 1, 4'hF, 4'd0, 1'b1, 1'b0);
    run_op("after_err", 8'd17, 4'd3, 4, 4'd5, 4'd2, 1'b0, 1'b0);

    // START during RUN must be ignored and not queued.
    launch(8'd200, 4'd13);
    chk("ign_accept", bus.READY, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.START = 1'b1;
    bus.N     = 8'd17;
    bus.D     = 4'd3;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    chk("ign_busy_k2", bus.READY, 1'b0);
    @(posedge clk);
    #1;
    chk("ign_busy_k3", bus.READY, 1'b0);
    @(posedge clk);
    #1;
    chk("ign_ready_k4", bus.READY, 1'b1);
    chk("ign_q", bus.Q, 4'd15);
    chk("ign_r", bus.R, 4'd5);
    @(posedge clk);
    #1;
    chk("ign_no_queue", bus.READY, 1'b1);
    chk("ign_q_stable", bus.Q, 4'd15);

    // Asynchronous reset in the middle of RUN.
    launch(8'd100, 4'd7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", bus.READY, 1'b1);
    chk("mid_rst_q", bus.Q, 4'h0);
    chk("mid_rst_r", bus.R, 4'h0);
    chk("mid_rst_ovf", bus.OVF, 1'b0);
    chk("mid_rst_divz", bus.DIVZ, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 8'd17, 4'd3, 4, 4'd5, 4'd2, 1'b0, 1'b0);

    // Every non-overflowing pair, checked against the multiply-back relation.
    for (int d = 1; d < 16; d++) begin
      for (int n = 0; n < 16 * d; n++) begin
        int q;
        int r;
        launch(8'(n), 4'(d));
        wait_ready(lat);
        q = int'(bus.Q);
        r = int'(bus.R);
        chk("sweep_lat", lat, 4);
        chk("sweep_qd_plus_r", q * d + r, n);
        chk("sweep_r_lt_d", (r < d) ? 1 : 0, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
